// File: rtl/run_ctrl_pkg.sv
// Shared definitions for run_ctrl: controller state encoding (doubles as the
// mode/LED code) and the board button roles.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        RESET = 2'b00,
        HALT  = 2'b01,
        RUN   = 2'b10,
        STEP  = 2'b11
    } run_state_t;

    localparam int BTN_RUN  = 0;
    localparam int BTN_RST  = 1;
    localparam int BTN_STEP = 2;

endpackage

// File: rtl/run_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus stability counter for one active-low
// button; emits a one-cycle registered pulse on each accepted press.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int            CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync0 <= i_btn_n;
            r_sync1 <= r_sync0;
            r_press <= 1'b0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // Accepting a change away from a released level is a press.
                r_cnt   <= '0;
                r_level <= r_sync1;
                r_press <= r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: debounced board buttons driving a RESET/HALT/RUN/STEP controller
// for the CPU reset and halt lines. STEP exists only with RUN_CTRL_STEP_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int N_BTN      = 3,
    parameter int DEB_CYCLES = 500000,
    parameter int RST_CYCLES = 16,
    parameter int BOOT_RUN   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic             cpu_nrst,
    output logic             cpu_halt,
    output logic [N_BTN-1:0] btn_press,
    output logic [1:0]       mode
);

    localparam int            RW       = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES);
`ifdef RUN_CTRL_STEP_EN
    localparam bit STEP_ON = 1'b1;
`else
    localparam bit STEP_ON = 1'b0;
`endif

    logic [N_BTN-1:0] w_press;
    run_state_t       r_state;
    logic [RW-1:0]    r_cnt;
    logic             r_boot;
    logic             r_nrst;
    logic             r_halt;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_btn_n(btn_n[gi]),
            .o_press(w_press[gi])
        );
    end

    // r_boot marks the stretch that follows rst; only that one may boot into RUN.
    always_ff @(posedge clk) begin
        if (rst || w_press[BTN_RST]) begin
            r_state <= RESET;
            r_cnt   <= RST_LOAD;
            r_boot  <= rst;
            r_nrst  <= 1'b0;
            r_halt  <= 1'b1;
        end else begin
            case (r_state)
                RESET: begin
                    if (r_cnt == RW'(1)) begin
                        r_nrst <= 1'b1;
                        r_boot <= 1'b0;
                        if ((BOOT_RUN != 0) && r_boot) begin
                            r_state <= RUN;
                            r_halt  <= 1'b0;
                        end else begin
                            r_state <= HALT;
                        end
                    end else begin
                        r_cnt <= r_cnt - RW'(1);
                    end
                end
                HALT: begin
                    if (w_press[BTN_RUN]) begin
                        r_state <= RUN;
                        r_halt  <= 1'b0;
                    end else if (STEP_ON && w_press[BTN_STEP]) begin
                        r_state <= STEP;
                        r_halt  <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_press[BTN_STEP]) begin
                        r_state <= HALT;
                        r_halt  <= 1'b1;
                    end
                end
                default: begin
                    // STEP lasts exactly one cycle.
                    r_state <= HALT;
                    r_halt  <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_nrst  = r_nrst;
    assign cpu_halt  = r_halt;
    assign btn_press = w_press;
    assign mode      = r_state;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: two instances (BOOT_RUN=0/RST=3 and BOOT_RUN=1/RST=16)
// share the buttons; a behavioural model is checked every cycle.
`timescale 1ns/1ps
module tb_run_ctrl;

    localparam int DEB  = 4;
    localparam int RST0 = 3;
    localparam int RST1 = 16;
`ifdef RUN_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif
    localparam int S_RESET = 0, S_HALT = 1, S_RUN = 2, S_STEP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_n = 3'b111;
    logic       nrst0, halt0, nrst1, halt1;
    logic [2:0] press0, press1;
    logic [1:0] mode0, mode1;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    run_ctrl #(.N_BTN(3), .DEB_CYCLES(DEB), .RST_CYCLES(RST0), .BOOT_RUN(0)) u_dut0 (
        .clk(clk), .rst(rst), .btn_n(btn_n), .cpu_nrst(nrst0),
        .cpu_halt(halt0), .btn_press(press0), .mode(mode0)
    );
    run_ctrl #(.N_BTN(3), .DEB_CYCLES(DEB), .RST_CYCLES(RST1), .BOOT_RUN(1)) u_dut1 (
        .clk(clk), .rst(rst), .btn_n(btn_n), .cpu_nrst(nrst1),
        .cpu_halt(halt1), .btn_press(press1), .mode(mode1)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Model: a button is accepted after DEB consecutive synchronised samples
    // disagreeing with its accepted level; the controller counts down the
    // remaining reset-stretch cycles.
    bit [1:0] m_pipe[3];
    bit       m_acc[3];
    int       m_streak[3];
    bit [2:0] m_press;
    int       m_st[2];
    int       m_left[2];
    bit       m_boot[2];
    int       m_rst_len[2] = '{RST0, RST1};
    bit       m_boot_run[2] = '{1'b0, 1'b1};
    bit       m_valid = 1'b0;

    task automatic model_edge();
        bit [2:0] p;
        bit       s;
        p = m_press;
        for (int i = 0; i < 2; i++) begin
            if (rst || p[1]) begin
                m_st[i]   = S_RESET;
                m_left[i] = m_rst_len[i];
                m_boot[i] = rst;
            end else begin
                case (m_st[i])
                    S_RESET: begin
                        m_left[i] = m_left[i] - 1;
                        if (m_left[i] == 0) begin
                            m_st[i]   = (m_boot_run[i] && m_boot[i]) ? S_RUN : S_HALT;
                            m_boot[i] = 1'b0;
                        end
                    end
                    S_HALT: begin
                        if (p[0]) m_st[i] = S_RUN;
                        else if (p[2] && STEP_EN) m_st[i] = S_STEP;
                    end
                    S_RUN: if (p[2]) m_st[i] = S_HALT;
                    default: m_st[i] = S_HALT;
                endcase
            end
        end
        for (int b = 0; b < 3; b++) begin
            m_press[b] = 1'b0;
            if (rst) begin
                m_pipe[b]   = 2'b11;
                m_acc[b]    = 1'b1;
                m_streak[b] = 0;
            end else begin
                s         = m_pipe[b][1];
                m_pipe[b] = {m_pipe[b][0], btn_n[b]};
                if (s == m_acc[b]) begin
                    m_streak[b] = 0;
                end else begin
                    m_streak[b] = m_streak[b] + 1;
                    if (m_streak[b] == DEB) begin
                        m_press[b]  = (s == 1'b0);
                        m_acc[b]    = s;
                        m_streak[b] = 0;
                    end
                end
            end
        end
        m_valid = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            cmp("model_mode0",  32'(mode0),  m_st[0]);
            cmp("model_nrst0",  32'(nrst0),  32'(m_st[0] != S_RESET));
            cmp("model_halt0",  32'(halt0),  32'(!(m_st[0] == S_RUN || m_st[0] == S_STEP)));
            cmp("model_press0", 32'(press0), 32'(m_press));
            cmp("model_mode1",  32'(mode1),  m_st[1]);
            cmp("model_nrst1",  32'(nrst1),  32'(m_st[1] != S_RESET));
            cmp("model_halt1",  32'(halt1),  32'(!(m_st[1] == S_RUN || m_st[1] == S_STEP)));
            cmp("model_press1", 32'(press1), 32'(m_press));
        end
    end

    initial begin
        // Power-on reset, 2 cycles.
        step(1);
        cmp("rst_mode",  32'(mode0),  0);
        cmp("rst_nrst",  32'(nrst0),  0);
        cmp("rst_halt",  32'(halt0),  1);
        cmp("rst_press", 32'(press0), 0);
        step(1);
        rst = 1'b0;
        step(2);
        cmp("stretch_nrst0", 32'(nrst0), 0);
        step(1);
        cmp("boot_mode0", 32'(mode0), 1);
        cmp("boot_halt0", 32'(halt0), 1);
        cmp("boot_nrst0", 32'(nrst0), 1);
        step(12);
        cmp("boot_stretch1", 32'(mode1), 0);
        step(1);
        cmp("boot_run1", 32'(mode1), 2);
        cmp("boot_halt1", 32'(halt1), 0);

        // Run press from HALT.
        btn_n[0] = 1'b0;
        step(5);
        cmp("run_early", 32'(press0), 0);
        step(1);
        cmp("run_press", 32'(press0), 1);
        step(1);
        cmp("run_mode", 32'(mode0), 2);
        cmp("run_halt", 32'(halt0), 0);
        btn_n[0] = 1'b1;
        step(8);

        // Step press in RUN pauses.
        btn_n[2] = 1'b0;
        step(6);
        cmp("pause_press", 32'(press0), 4);
        step(1);
        cmp("pause_mode", 32'(mode0), 1);
        cmp("pause_halt", 32'(halt0), 1);
        btn_n[2] = 1'b1;
        step(8);

        // Bouncing step button, then held low.
        n = 0;
        for (int i = 0; i < 10; i++) begin
            btn_n[2] = i[0];
            repeat (2) begin
                step(1);
                if (press0[2]) n++;
            end
        end
        btn_n[2] = 1'b0;
        repeat (5) begin
            step(1);
            if (press0[2]) n++;
        end
        cmp("bounce_nopulse", n, 0);
        step(1);
        cmp("step_press", 32'(press0), 4);
        step(1);
        cmp("step_mode", 32'(mode0), STEP_EN ? 3 : 1);
        cmp("step_halt", 32'(halt0), STEP_EN ? 0 : 1);
        step(1);
        cmp("step_back_mode", 32'(mode0), 1);
        cmp("step_back_halt", 32'(halt0), 1);
        step(6);
        cmp("step_no_repeat", 32'(mode0), 1);
        btn_n[2] = 1'b1;
        step(8);

        // Into RUN, then run and reset together, then a second reset press.
        btn_n[0] = 1'b0;
        step(7);
        cmp("rerun_mode", 32'(mode0), 2);
        btn_n[0] = 1'b1;
        step(8);
        btn_n = 3'b100;
        step(6);
        cmp("dual_press", 32'(press0), 3);
        btn_n = 3'b111;
        step(1);
        cmp("dual_mode0", 32'(mode0), 0);
        cmp("dual_nrst0", 32'(nrst0), 0);
        cmp("dual_mode1", 32'(mode1), 0);
        step(2);
        cmp("dual_nrst0_end", 32'(nrst0), 0);
        step(1);
        cmp("dual_halt_mode0", 32'(mode0), 1);
        cmp("dual_halt_nrst0", 32'(nrst0), 1);
        step(2);
        btn_n = 3'b101;
        step(6);
        cmp("rst2_press", 32'(press0), 2);
        btn_n = 3'b111;
        step(1);
        cmp("rst2_mode0", 32'(mode0), 0);
        step(3);
        cmp("rst2_done0", 32'(mode0), 1);
        step(1);
        cmp("restart_mode1", 32'(mode1), 0);
        step(11);
        cmp("restart_late1", 32'(mode1), 0);
        step(1);
        cmp("press_rst_halt1", 32'(mode1), 1);
        cmp("press_rst_halt1_h", 32'(halt1), 1);

        // rst during debounce progress discards it.
        btn_n[0] = 1'b0;
        step(4);
        rst = 1'b1;
        btn_n[0] = 1'b1;
        step(1);
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            if (press0 != 3'b000) n++;
            step(1);
        end
        cmp("midrst_nopulse", n, 0);
        step(5);
        cmp("midrst_stretch1", 32'(mode1), 0);
        step(1);
        cmp("midrst_run1", 32'(mode1), 2);
        cmp("midrst_halt0", 32'(mode0), 1);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
